csr_arbiter: RTL and testbench
==============================

Name: csr_arbiter

Overview:
- Shares the single CSR access port (csr_enable/csr_addr/rs1_data/rs1_zimm/csr_op) between Requesters sources: core pipeline, interrupt controller and debug unit.
- Round-robin arbitration with an optional per-requester lock, so read-modify-write sequences stay atomic.
- Routes the blocked-address gate result (the block-list csr_enable_out) back to the granted requester as a blocked response.
- Sits between the requesters and the CSR block/csr instances.

Parameters:
- Requesters, 3, number of requesting sources (2..8).
- LockMax, 16, maximum consecutive cycles a lock is held before forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  Requesters  per-source request valid.
- req_lock  in  Requesters  keep grant after this access.
- req_addr  in  Requesters x CsrAddrT  CSR address per source.
- req_data  in  Requesters x word  rs1 data per source.
- req_zimm  in  Requesters x r  zimm per source.
- req_op  in  Requesters x csr_op_t  operation per source.
- req_ready  out  Requesters  one-cycle completion pulse.
- req_blocked  out  1  qualifies req_ready: access was suppressed by the block list.
- csr_enable  out  1  downstream enable.
- csr_addr  out  CsrAddrT  downstream address.
- rs1_data  out  word  downstream data.
- rs1_zimm  out  r  downstream zimm.
- csr_op  out  csr_op_t  downstream op.
- csr_gate  in  1  gated enable returned by the block list (csr_enable_out).
- grant_id  out  $clog2(Requesters)  current or last granted source.
- locked  out  1  arbiter is in LOCKED.

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_ptr=0; grant_id=0; lock_cnt=0; all outputs 0 (csr_enable, csr_addr, rs1_data, rs1_zimm, csr_op, req_ready, req_blocked, locked).
- FSM states: IDLE, ISSUE, LOCKED.
- IDLE:
  - If any req_valid, select the first valid index searching from rr_ptr upward, wrapping modulo Requesters.
  - Register grant_id and that source's addr/data/zimm/op into the output registers; go to ISSUE.
  - If no req_valid, stay in IDLE; csr_enable=0.
- ISSUE (exactly one cycle):
  - csr_enable=1 with the registered payload.
  - req_ready[grant_id]=1; req_blocked = ~csr_gate, sampled combinationally in the same cycle. All other req_ready bits are 0.
  - rr_ptr <= (grant_id+1) mod Requesters.
  - Next state: LOCKED if req_lock[grant_id]=1 and lock_cnt<LockMax; otherwise IDLE.
- LOCKED:
  - locked=1; csr_enable=0; other sources are ignored.
  - If req_valid[grant_id]=1: latch its payload, lock_cnt+=1, go to ISSUE.
  - If req_valid[grant_id]=0 and req_lock[grant_id]=0: release to IDLE, lock_cnt=0.
  - Otherwise lock_cnt+=1 each idle locked cycle.
  - If lock_cnt reaches LockMax: forced release to IDLE, lock_cnt=0.
  - lock_cnt is cleared on every entry to IDLE.
- Latency: request seen in cycle N produces csr_enable and req_ready in cycle N+1 (from IDLE or LOCKED). Maximum throughput is one access per 2 cycles.
- Handshake: a requester holds valid/payload until req_ready. The payload is latched at grant, so withdrawing valid after grant does not cancel the access; the ready pulse is still emitted.
- Simultaneous requests: round-robin order from rr_ptr. A requester re-requesting immediately after service has lowest priority (unless locked).
- The block list observes the same csr_addr/csr_enable.
  - A blocked access still completes the handshake: req_ready=1, req_blocked=1.
  - No retry is performed.
- grant_id and rr_ptr wrap modulo Requesters (non-power-of-two counts supported).
- Reset asserted mid-ISSUE or mid-LOCKED aborts immediately to IDLE with all outputs cleared. No req_ready is emitted for the aborted access.

Test Plan:
- Single request: req_valid=3'b010, addr=0x300, op=write, csr_gate=1 -> cycle N+1: csr_enable=1, csr_addr=0x300, req_ready=3'b010, req_blocked=0; IDLE at N+2.
- Fairness: all three valid continuously, no lock -> grants 0,1,2,0,1,2; one ready every 2 cycles; rr_ptr wraps 2->0.
- Blocked access: source 0, addr=0x305, csr_gate=0 in ISSUE -> req_ready[0]=1, req_blocked=1; next grant proceeds normally.
- Lock: source 2 issues with req_lock=1 while 0 and 1 are valid -> locked=1; source 2's next two accesses served back-to-back with no grants to 0/1; lock dropped -> IDLE, next grant to 0.
- Lock timeout: LockMax=4, source 1 holds lock with valid=0 -> released to IDLE after 4 locked cycles, locked=0, lock_cnt=0.
- Async reset: reset driven 0 mid-ISSUE (between clock edges) -> csr_enable, req_ready, locked are 0 immediately; after release the first grant goes to source 0.

Source files
------------

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing the single CSR access port among several requesters,
// with an optional per-requester lock for atomic read-modify-write sequences.
module csr_arbiter #(
   parameter int unsigned Requesters = 3,
   parameter int unsigned LockMax    = 16,
   parameter int unsigned AddrW      = 12,
   parameter int unsigned DataW      = 32,
   parameter int unsigned ZimmW      = 5,
   parameter int unsigned OpW        = 2,
   localparam int unsigned GrantW    = (Requesters > 1) ? $clog2(Requesters) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [Requesters-1:0]                 req_valid,
   input  logic [Requesters-1:0]                 req_lock,
   input  logic [Requesters-1:0][AddrW-1:0]      req_addr,
   input  logic [Requesters-1:0][DataW-1:0]      req_data,
   input  logic [Requesters-1:0][ZimmW-1:0]      req_zimm,
   input  logic [Requesters-1:0][OpW-1:0]        req_op,
   output logic [Requesters-1:0]                 req_ready,
   output logic                                  req_blocked,
   output logic                                  csr_enable,
   output logic [AddrW-1:0]                      csr_addr,
   output logic [DataW-1:0]                      rs1_data,
   output logic [ZimmW-1:0]                      rs1_zimm,
   output logic [OpW-1:0]                        csr_op,
   input  logic                                  csr_gate,
   output logic [GrantW-1:0]                     grant_id,
   output logic                                  locked
);

   localparam int unsigned CntW = $clog2(LockMax + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [GrantW-1:0]   rr_ptr, rr_ptr_d;
   logic [GrantW-1:0]   grant_d;
   logic [GrantW-1:0]   sel_idx;
   logic [GrantW-1:0]   probe;
   logic [GrantW-1:0]   next_ptr;
   logic [GrantW-1:0]   load_idx;
   logic                sel_valid;
   logic                load;
   logic [CntW-1:0]     lock_cnt, lock_cnt_d;

   // First valid source at or after rr_ptr, walking with an explicit wrap so
   // non-power-of-two requester counts never index past the last source.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      probe     = rr_ptr;
      for (int unsigned i = 0; i < Requesters; i++) begin
         if (!sel_valid && req_valid[probe]) begin
            sel_valid = 1'b1;
            sel_idx   = probe;
         end
         probe = (probe == GrantW'(Requesters - 1)) ? '0 : probe + 1'b1;
      end
   end

   assign next_ptr = (grant_id == GrantW'(Requesters - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      state_d     = state;
      rr_ptr_d    = rr_ptr;
      grant_d     = grant_id;
      lock_cnt_d  = lock_cnt;
      load        = 1'b0;
      load_idx    = grant_id;
      req_ready   = '0;
      req_blocked = 1'b0;
      csr_enable  = 1'b0;
      locked      = 1'b0;

      case (state)
         IDLE: begin
            lock_cnt_d = '0;
            if (sel_valid) begin
               grant_d  = sel_idx;
               load     = 1'b1;
               load_idx = sel_idx;
               state_d  = ISSUE;
            end
         end

         ISSUE: begin
            csr_enable          = 1'b1;
            req_ready[grant_id] = 1'b1;
            req_blocked         = ~csr_gate;
            rr_ptr_d            = next_ptr;
            if (req_lock[grant_id] && (lock_cnt < CntW'(LockMax))) begin
               state_d = LOCKED;
            end else begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
         end

         LOCKED: begin
            locked = 1'b1;
            if (req_valid[grant_id]) begin
               load       = 1'b1;
               lock_cnt_d = lock_cnt + 1'b1;
               state_d    = ISSUE;
            end else if (!req_lock[grant_id]) begin
               lock_cnt_d = '0;
               state_d    = IDLE;
            end else if (lock_cnt >= CntW'(LockMax - 1)) begin
               // This idle cycle brings the count to LockMax: forced release.
               lock_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               lock_cnt_d = lock_cnt + 1'b1;
            end
         end

         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         lock_cnt <= '0;
         csr_addr <= '0;
         rs1_data <= '0;
         rs1_zimm <= '0;
         csr_op   <= '0;
      end else begin
         state    <= state_d;
         rr_ptr   <= rr_ptr_d;
         grant_id <= grant_d;
         lock_cnt <= lock_cnt_d;
         if (load) begin
            csr_addr <= req_addr[load_idx];
            rs1_data <= req_data[load_idx];
            rs1_zimm <= req_zimm[load_idx];
            csr_op   <= req_op[load_idx];
         end
      end
   end

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: directed vector table, lock/timeout/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_csr_arbiter;

   localparam int unsigned N       = 3;
   localparam int unsigned LOCKMAX = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [N-1:0]         req_valid = '0;
   logic [N-1:0]         req_lock = '0;
   logic [N-1:0][11:0]   req_addr = '0;
   logic [N-1:0][31:0]   req_data = '0;
   logic [N-1:0][4:0]    req_zimm = '0;
   logic [N-1:0][1:0]    req_op = '0;
   logic [N-1:0]         req_ready;
   logic                 req_blocked;
   logic                 csr_enable;
   logic [11:0]          csr_addr;
   logic [31:0]          rs1_data;
   logic [4:0]           rs1_zimm;
   logic [1:0]           csr_op;
   logic                 csr_gate = 1'b1;
   logic [1:0]           grant_id;
   logic                 locked;

   int unsigned checks = 0;
   int unsigned errors = 0;

   csr_arbiter #(.Requesters(N), .LockMax(LOCKMAX)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
      .req_data(req_data), .req_zimm(req_zimm), .req_op(req_op),
      .req_ready(req_ready), .req_blocked(req_blocked),
      .csr_enable(csr_enable), .csr_addr(csr_addr), .rs1_data(rs1_data),
      .rs1_zimm(rs1_zimm), .csr_op(csr_op), .csr_gate(csr_gate),
      .grant_id(grant_id), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  lock;
      logic        gate;
      logic        en;
      logic [2:0]  ready;
      logic        blocked;
      logic        lk;
      logic [1:0]  gid;
      logic [11:0] addr;
   } vec_t;

   vec_t tbl [14];

   // Reference model state: one access "in flight" or a lock held by m_gid.
   bit          m_busy, m_lk;
   int unsigned m_ptr, m_gid, m_hold;
   logic [11:0] m_addr;
   logic [31:0] m_data;
   logic [4:0]  m_zimm;
   logic [1:0]  m_op;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [2:0] rdy,
                             input logic blk, input logic lk, input logic [1:0] gid);
      chk({tag, "_en"}, 64'(csr_enable), 64'(en));
      chk({tag, "_ready"}, 64'(req_ready), 64'(rdy));
      chk({tag, "_blocked"}, 64'(req_blocked), 64'(blk));
      chk({tag, "_locked"}, 64'(locked), 64'(lk));
      chk({tag, "_gid"}, 64'(grant_id), 64'(gid));
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic g);
      @(posedge clk);
      #1;
      req_valid = v;
      req_lock  = l;
      csr_gate  = g;
      @(negedge clk);
   endtask

   task automatic fixed_payload();
      req_addr[0] = 12'h305;
      req_addr[1] = 12'h300;
      req_addr[2] = 12'h341;
      for (int i = 0; i < 3; i++) begin
         req_data[i] = 32'hA000_0000 | 32'(i);
         req_zimm[i] = 5'(i + 1);
         req_op[i]   = 2'd1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      csr_gate  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b1;
      m_busy = 0; m_lk = 0; m_ptr = 0; m_gid = 0; m_hold = 0;
   endtask

   task automatic model_latch(input int unsigned k);
      m_addr = req_addr[k];
      m_data = req_data[k];
      m_zimm = req_zimm[k];
      m_op   = req_op[k];
   endtask

   // Advance the model by one clock edge given the inputs present before it.
   task automatic model_step(input logic [2:0] v, input logic [2:0] l);
      if (m_busy) begin
         m_ptr  = (m_gid + 1) % N;
         m_busy = 0;
         if (l[m_gid] && m_hold < LOCKMAX) m_lk = 1;
         else m_hold = 0;
      end else if (m_lk) begin
         if (v[m_gid]) begin
            model_latch(m_gid);
            m_hold++;
            m_busy = 1;
            m_lk   = 0;
         end else if (!l[m_gid]) begin
            m_lk = 0; m_hold = 0;
         end else begin
            m_hold++;
            if (m_hold >= LOCKMAX) begin m_lk = 0; m_hold = 0; end
         end
      end else begin
         m_hold = 0;
         for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            k = (m_ptr + i) % N;
            if (!m_busy && v[k]) begin
               m_gid  = k;
               model_latch(k);
               m_busy = 1;
            end
         end
      end
   endtask

   initial begin
      tbl[0]  = '{3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 12'h000};
      tbl[1]  = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 2'd1, 12'h300};
      tbl[2]  = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 12'h000};
      tbl[3]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 12'h000};
      tbl[4]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 2'd2, 12'h341};
      tbl[5]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 12'h000};
      tbl[6]  = '{3'b111, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 12'h305};
      tbl[7]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 12'h000};
      tbl[8]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 2'd1, 12'h300};
      tbl[9]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 12'h000};
      tbl[10] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 2'd2, 12'h341};
      tbl[11] = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 12'h000};
      tbl[12] = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 12'h305};
      tbl[13] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 12'h000};

      fixed_payload();
      #12;
      expect_out("reset", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      chk("reset_addr", 64'(csr_addr), 64'(0));
      chk("reset_data", 64'(rs1_data), 64'(0));
      @(negedge clk);
      reset = 1'b1;

      // Single request, fairness with wrap, blocked access.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].valid, tbl[i].lock, tbl[i].gate);
         expect_out($sformatf("tbl%0d", i), tbl[i].en, tbl[i].ready, tbl[i].blocked,
                    tbl[i].lk, tbl[i].gid);
         if (tbl[i].en) begin
            chk($sformatf("tbl%0d_addr", i), 64'(csr_addr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_data", i), 64'(rs1_data), 64'(32'hA000_0000 | 32'(tbl[i].gid)));
            chk($sformatf("tbl%0d_zimm", i), 64'(rs1_zimm), 64'(tbl[i].gid) + 64'd1);
            chk($sformatf("tbl%0d_op", i), 64'(csr_op), 64'(1));
         end
      end

      // Lock: source 2 keeps the port while 0 and 1 wait.
      drive(3'b100, 3'b100, 1'b1); expect_out("lk0", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      drive(3'b111, 3'b100, 1'b1); expect_out("lk1", 1'b1, 3'b100, 1'b0, 1'b0, 2'd2);
      drive(3'b111, 3'b100, 1'b1); expect_out("lk2", 1'b0, 3'b000, 1'b0, 1'b1, 2'd2);
      drive(3'b111, 3'b100, 1'b1); expect_out("lk3", 1'b1, 3'b100, 1'b0, 1'b0, 2'd2);
      drive(3'b111, 3'b100, 1'b1); expect_out("lk4", 1'b0, 3'b000, 1'b0, 1'b1, 2'd2);
      drive(3'b011, 3'b000, 1'b1); expect_out("lk5", 1'b1, 3'b100, 1'b0, 1'b0, 2'd2);
      drive(3'b011, 3'b000, 1'b1); expect_out("lk6", 1'b0, 3'b000, 1'b0, 1'b0, 2'd2);
      drive(3'b000, 3'b000, 1'b1); expect_out("lk7", 1'b1, 3'b001, 1'b0, 1'b0, 2'd0);
      drive(3'b000, 3'b000, 1'b1); expect_out("lk8", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);

      // Lock timeout: source 1 holds the lock without requesting.
      drive(3'b010, 3'b010, 1'b1); expect_out("to0", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      drive(3'b000, 3'b010, 1'b1); expect_out("to1", 1'b1, 3'b010, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 4; i++) begin
         drive(3'b000, 3'b010, 1'b1);
         expect_out($sformatf("to_hold%0d", i), 1'b0, 3'b000, 1'b0, 1'b1, 2'd1);
      end
      drive(3'b010, 3'b010, 1'b1); expect_out("to_rel", 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);
      drive(3'b010, 3'b010, 1'b1); expect_out("to_iss", 1'b1, 3'b010, 1'b0, 1'b0, 2'd1);
      drive(3'b000, 3'b000, 1'b1); expect_out("to_relock", 1'b0, 3'b000, 1'b0, 1'b1, 2'd1);
      drive(3'b000, 3'b000, 1'b1); expect_out("to_drop", 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);

      // Async reset in the middle of an ISSUE cycle.
      drive(3'b010, 3'b000, 1'b1);
      @(posedge clk);
      #1;
      req_valid = '0;
      chk("ar_pre_en", 64'(csr_enable), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      expect_out("ar_mid", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      chk("ar_mid_addr", 64'(csr_addr), 64'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(3'b111, 3'b000, 1'b1); expect_out("ar_idle", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      drive(3'b000, 3'b000, 1'b1); expect_out("ar_first", 1'b1, 3'b001, 1'b0, 1'b0, 2'd0);

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [2:0] v, l, er;
         @(posedge clk);
         #1;
         v = 3'($urandom_range(0, 7));
         l = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         req_valid = v;
         req_lock  = l;
         csr_gate  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 3; i++) begin
            req_addr[i] = 12'($urandom);
            req_data[i] = $urandom;
            req_zimm[i] = 5'($urandom);
            req_op[i]   = 2'($urandom);
         end
         @(negedge clk);
         er = m_busy ? 3'(3'b001 << m_gid) : 3'b000;
         chk("rnd_en", 64'(csr_enable), 64'(m_busy));
         chk("rnd_ready", 64'(req_ready), 64'(er));
         chk("rnd_blocked", 64'(req_blocked), 64'(m_busy & ~csr_gate));
         chk("rnd_locked", 64'(locked), 64'(m_lk));
         chk("rnd_gid", 64'(grant_id), 64'(m_gid));
         if (m_busy) begin
            chk("rnd_addr", 64'(csr_addr), 64'(m_addr));
            chk("rnd_data", 64'(rs1_data), 64'(m_data));
            chk("rnd_zimm", 64'(rs1_zimm), 64'(m_zimm));
            chk("rnd_op", 64'(csr_op), 64'(m_op));
         end
         model_step(v, l);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
